// File: rtl/pixel_streamer_pkg.sv
// Shared stream definitions: controller state encoding and the tag fields
// that travel beside every pixel from read issue to output.
package pixel_streamer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } stream_state_t;

   localparam int TAG_W = 2;

   typedef struct packed {
      logic eor;
      logic eof;
   } stream_tag_t;

endpackage : pixel_streamer_pkg

// File: rtl/pixel_streamer_fifo2.sv
// Two-entry output FIFO holding {eor, eof, data}; the head entry drives the
// stream outputs directly so they stay stable while the consumer stalls.
module stream_fifo2 #(
   parameter int WIDTH = 10
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_empty,
   output logic [1:0]       o_count
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             do_wr;
   logic             do_rd;

   assign do_rd = i_rd_en && (count != 2'd0);
   // A full FIFO can still accept a word in the same cycle its head leaves.
   assign do_wr = i_wr_en && ((count != 2'd2) || do_rd);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= i_wr_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_rd) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, do_wr} - {1'b0, do_rd};
      end
   end

   assign o_rd_data = mem[rd_ptr];
   assign o_empty   = (count == 2'd0);
   assign o_count   = count;

endmodule : stream_fifo2

// File: rtl/pixel_streamer.sv
// Streams one frame from a 1-cycle-latency frame memory in raster order,
// tagging end-of-row / end-of-frame, with ready/valid backpressure.
module pixel_streamer
   import pixel_streamer_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MAX_IMG_W = 640,
   parameter int MAX_IMG_H = 480,
   parameter int ADDR_W    = $clog2(MAX_IMG_W * MAX_IMG_H)
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_start,
   input  logic [$clog2(MAX_IMG_W+1)-1:0] i_img_w,
   input  logic [$clog2(MAX_IMG_H+1)-1:0] i_img_h,
   output logic                           o_rd_en,
   output logic [ADDR_W-1:0]              o_rd_addr,
   input  logic [DATA_W-1:0]              i_rd_data,
   input  logic                           i_rdy,
   output logic                           o_vld,
   output logic                           o_eor,
   output logic                           o_eof,
   output logic [DATA_W-1:0]              o_data,
   output logic                           o_busy,
   output logic                           o_done
);

   localparam int CW      = $clog2(MAX_IMG_W + 1);
   localparam int HW      = $clog2(MAX_IMG_H + 1);
   localparam int ENTRY_W = TAG_W + DATA_W;

   stream_state_t state;
   stream_state_t next_state;

   logic [CW-1:0]     img_w_r;
   logic [HW-1:0]     img_h_r;
   logic [CW-1:0]     col;
   logic [HW-1:0]     row;
   logic [ADDR_W-1:0] addr;
   logic              in_flight;
   stream_tag_t       tag_d;
   stream_tag_t       issue_tag;
   logic              done_r;
   logic              rd_en;
   logic              start_ok;
   logic              can_issue;
   logic [2:0]        outstanding;

   logic               fifo_pop;
   logic               fifo_empty;
   logic [1:0]         fifo_count;
   logic [ENTRY_W-1:0] fifo_head;

   assign start_ok      = i_start && (i_img_w != '0) && (i_img_h != '0);
   assign fifo_pop      = o_vld && i_rdy;
   assign issue_tag.eor = (col == img_w_r - CW'(1));
   assign issue_tag.eof = issue_tag.eor && (row == img_h_r - HW'(1));

   // A word leaving the FIFO this cycle frees its slot, which keeps the
   // pipeline bubble-free while still bounding FIFO + in-flight to two.
   assign outstanding = 3'(fifo_count) + 3'(in_flight) - 3'(fifo_pop);
   assign can_issue   = (outstanding < 3'd2);

   always_comb begin
      next_state = state;
      rd_en      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_ok) next_state = ST_RUN;
         end
         ST_RUN: begin
            if (can_issue) begin
               rd_en = 1'b1;
               if (issue_tag.eof) next_state = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_pop && o_eof) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         img_w_r   <= '0;
         img_h_r   <= '0;
         col       <= '0;
         row       <= '0;
         addr      <= '0;
         in_flight <= 1'b0;
         tag_d     <= '0;
         done_r    <= 1'b0;
      end else begin
         state     <= next_state;
         in_flight <= rd_en;
         tag_d     <= issue_tag;
         done_r    <= 1'b0;
         if ((state == ST_IDLE) && i_start) begin
            if (start_ok) begin
               img_w_r <= i_img_w;
               img_h_r <= i_img_h;
               col     <= '0;
               row     <= '0;
               addr    <= '0;
            end else begin
               done_r <= 1'b1;
            end
         end
         if (rd_en) begin
            addr <= addr + ADDR_W'(1);
            if (issue_tag.eor) begin
               col <= '0;
               row <= row + HW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
         if ((state == ST_DRAIN) && fifo_pop && o_eof) begin
            done_r <= 1'b1;
         end
      end
   end

   stream_fifo2 #(
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wr_en   (in_flight),
      .i_wr_data ({tag_d.eor, tag_d.eof, i_rd_data}),
      .i_rd_en   (fifo_pop),
      .o_rd_data (fifo_head),
      .o_empty   (fifo_empty),
      .o_count   (fifo_count)
   );

   assign o_vld                  = !fifo_empty;
   assign {o_eor, o_eof, o_data} = fifo_head;
   assign o_rd_en                = rd_en;
   assign o_rd_addr              = addr;
   assign o_busy                 = (state != ST_IDLE);
   assign o_done                 = done_r;

endmodule : pixel_streamer

// File: tb/tb_pixel_streamer.sv
// Directed bench for pixel_streamer: frame memory returns data = address,
// stream outputs are compared against hand-derived pixel/tag sequences.
module tb_pixel_streamer;

   localparam int DATA_W    = 16;
   localparam int MAX_IMG_W = 640;
   localparam int MAX_IMG_H = 480;
   localparam int ADDR_W    = $clog2(MAX_IMG_W * MAX_IMG_H);
   localparam int CW        = $clog2(MAX_IMG_W + 1);
   localparam int HW        = $clog2(MAX_IMG_H + 1);

   logic              i_clk;
   logic              i_rst_n;
   logic              i_start;
   logic [CW-1:0]     i_img_w;
   logic [HW-1:0]     i_img_h;
   logic              o_rd_en;
   logic [ADDR_W-1:0] o_rd_addr;
   logic [DATA_W-1:0] i_rd_data;
   logic              i_rdy;
   logic              o_vld;
   logic              o_eor;
   logic              o_eof;
   logic [DATA_W-1:0] o_data;
   logic              o_busy;
   logic              o_done;

   int tests_run    = 0;
   int tests_failed = 0;

   pixel_streamer #(
      .DATA_W    (DATA_W),
      .MAX_IMG_W (MAX_IMG_W),
      .MAX_IMG_H (MAX_IMG_H),
      .ADDR_W    (ADDR_W)
   ) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_start   (i_start),
      .i_img_w   (i_img_w),
      .i_img_h   (i_img_h),
      .o_rd_en   (o_rd_en),
      .o_rd_addr (o_rd_addr),
      .i_rd_data (i_rd_data),
      .i_rdy     (i_rdy),
      .o_vld     (o_vld),
      .o_eor     (o_eor),
      .o_eof     (o_eof),
      .o_data    (o_data),
      .o_busy    (o_busy),
      .o_done    (o_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Frame memory with one cycle of read latency; contents equal the address.
   always @(posedge i_clk) begin
      i_rd_data <= o_rd_en ? o_rd_addr[DATA_W-1:0] : 16'hDEAD;
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_output({tag, " vld"},  32'(o_vld),     0);
      check_output({tag, " eor"},  32'(o_eor),     0);
      check_output({tag, " eof"},  32'(o_eof),     0);
      check_output({tag, " rd_en"}, 32'(o_rd_en),  0);
      check_output({tag, " busy"}, 32'(o_busy),    0);
      check_output({tag, " done"}, 32'(o_done),    0);
      check_output({tag, " data"}, 32'(o_data),    0);
      check_output({tag, " addr"}, 32'(o_rd_addr), 0);
   endtask

   // Streams one frame and checks order, tags, stalls, read credit and done.
   task automatic apply_frame(input int w, input int h, input bit use_stall,
                              input bit restart_mid);
      int          idx       = 0;
      int          issued    = 0;
      int          pending   = 0;
      int          first_vld = -1;
      int          eof_cycle = -1;
      int          done_seen = 0;
      bit          prev_stall = 1'b0;
      logic [DATA_W-1:0] prev_data = '0;
      logic        prev_eor = 1'b0;
      logic        prev_eof = 1'b0;
      bit          xfer;
      bit [3:0]    rdy_pat  = 4'b1001;

      @(negedge i_clk);
      i_img_w = CW'(w);
      i_img_h = HW'(h);
      i_start = 1'b1;
      i_rdy   = 1'b1;
      for (int c = 1; c < 5000; c++) begin
         @(negedge i_clk);
         i_start = restart_mid && (c == 4);
         i_rdy   = use_stall ? rdy_pat[(c - 1) % 4] : 1'b1;
         #1;
         xfer = o_vld && i_rdy;
         if (c == 1) check_output("busy after start", 32'(o_busy), 1);
         if (o_rd_en) begin
            check_output("read address", 32'(o_rd_addr), 32'(issued));
            issued++;
         end
         if (prev_stall) begin
            check_output("stall vld",  32'(o_vld),  1);
            check_output("stall data", 32'(o_data), 32'(prev_data));
            check_output("stall eor",  32'(o_eor),  32'(prev_eor));
            check_output("stall eof",  32'(o_eof),  32'(prev_eof));
         end
         if (o_vld && first_vld < 0) first_vld = c;
         if (!use_stall && first_vld >= 0 && idx < w * h)
            check_output("no bubble", 32'(o_vld), 1);
         if (o_done) begin
            done_seen++;
            check_output("done timing", 32'(c), 32'(eof_cycle + 1));
            check_output("pixels before done", 32'(idx), 32'(w * h));
            break;
         end
         if (xfer) begin
            check_output("pixel data", 32'(o_data), 32'(idx));
            check_output("pixel eor",  32'(o_eor),  32'((idx % w) == w - 1));
            check_output("pixel eof",  32'(o_eof),  32'(idx == w * h - 1));
            if (idx == w * h - 1) eof_cycle = c;
            idx++;
         end
         pending = pending + int'(o_rd_en) - int'(xfer);
         if (pending > 2) check_output("outstanding reads", 32'(pending), 2);
         prev_stall = o_vld && !i_rdy;
         prev_data  = o_data;
         prev_eor   = o_eor;
         prev_eof   = o_eof;
      end
      i_start = 1'b0;
      i_rdy   = 1'b1;
      check_output("done count", 32'(done_seen), 1);
      check_output("first valid cycle", 32'(first_vld), 3);
      check_output("reads issued", 32'(issued), 32'(w * h));
      for (int c = 0; c < 4; c++) begin
         @(negedge i_clk);
         #1;
         check_output("post frame done", 32'(o_done), 0);
         check_output("post frame vld",  32'(o_vld),  0);
         check_output("post frame busy", 32'(o_busy), 0);
      end
   endtask

   initial begin
      bit seen5;
      i_rst_n = 1'b0;
      i_start = 1'b0;
      i_img_w = '0;
      i_img_h = '0;
      i_rdy   = 1'b1;
      repeat (2) @(negedge i_clk);
      #1;
      check_idle_outputs("reset");
      @(negedge i_clk);
      i_rst_n = 1'b1;

      apply_frame(4, 3, 1'b0, 1'b0);
      apply_frame(4, 3, 1'b1, 1'b0);

      // Zero width: immediate done, nothing read or emitted.
      @(negedge i_clk);
      i_img_w = '0;
      i_img_h = HW'(5);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      #1;
      check_output("zero size done", 32'(o_done), 1);
      check_output("zero size busy", 32'(o_busy), 0);
      for (int c = 0; c < 6; c++) begin
         check_output("zero size vld",   32'(o_vld),   0);
         check_output("zero size rd_en", 32'(o_rd_en), 0);
         @(negedge i_clk);
         #1;
         check_output("zero size done once", 32'(o_done), 0);
      end

      // Reset right after pixel 5 of a 4x3 frame, then a clean 2x2 frame.
      @(negedge i_clk);
      i_img_w = CW'(4);
      i_img_h = HW'(3);
      i_start = 1'b1;
      seen5   = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge i_clk);
         i_start = 1'b0;
         #1;
         if (o_vld && i_rdy && o_data == 16'd5) begin
            seen5 = 1'b1;
            break;
         end
      end
      check_output("reached pixel 5", 32'(seen5), 1);
      @(negedge i_clk);
      i_rst_n = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      check_idle_outputs("mid-frame reset");
      for (int c = 0; c < 6; c++) begin
         @(negedge i_clk);
         #1;
         check_output("abandoned vld",  32'(o_vld),  0);
         check_output("abandoned done", 32'(o_done), 0);
      end
      apply_frame(2, 2, 1'b0, 1'b0);

      apply_frame(4, 3, 1'b0, 1'b1);
      apply_frame(640, 2, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_pixel_streamer

// File: doc/pixel_streamer.md
PIXEL_STREAMER -- requirements
Module: pixel_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter MAX_IMG_W, default 640, maximum row length in pixels.
REQ-003 SHALL have parameter MAX_IMG_H, default 480, maximum rows per frame.
REQ-004 SHALL have parameter ADDR_W, default $clog2(MAX_IMG_W*MAX_IMG_H), frame-memory address width.
REQ-005 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port i_start  input  1  one-cycle request to stream one frame.
REQ-008 SHALL have port i_img_w  input  $clog2(MAX_IMG_W+1)  row length, sampled with i_start.
REQ-009 SHALL have port i_img_h  input  $clog2(MAX_IMG_H+1)  row count, sampled with i_start.
REQ-010 SHALL have port o_rd_en  output  1  frame-memory read strobe.
REQ-011 SHALL have port o_rd_addr  output  ADDR_W  frame-memory read address.
REQ-012 SHALL have port i_rd_data  input  DATA_W  read data, valid exactly one cycle after o_rd_en.
REQ-013 SHALL have port i_rdy  input  1  downstream ready.
REQ-014 SHALL have port o_vld  output  1  output pixel valid.
REQ-015 SHALL have port o_eor  output  1  marks last pixel of a row.
REQ-016 SHALL have port o_eof  output  1  marks last pixel of the frame.
REQ-017 SHALL have port o_data  output  DATA_W  pixel.
REQ-018 SHALL have port o_busy  output  1  frame in progress.
REQ-019 SHALL have port o_done  output  1  one-cycle pulse after last pixel accepted.

Function
REQ-020 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-021 IDLE: i_start=1 with nonzero width and height SHALL latch sizes, clear row/col/address counters, go RUN; i_start in RUN/DRAIN SHALL be ignored.
REQ-022 i_start with zero width or height SHALL pulse o_done next cycle, emit no pixels, stay IDLE.
REQ-023 RUN SHALL issue reads in raster order, address 0 to W*H-1, using an incrementing counter (no multiplier).
REQ-024 Read issue SHALL require (FIFO occupancy + reads in flight) < 2; a 2-entry output FIFO SHALL absorb every returned word, so no data is ever dropped.
REQ-025 RUN SHALL go DRAIN in the cycle after the read of address W*H-1 issues; DRAIN SHALL issue no reads.
REQ-026 Tags SHALL travel with data: o_eor=1 when col=W-1; o_eof=1 (with o_eor=1) for the final pixel only.
REQ-027 A transfer SHALL occur when o_vld && i_rdy; while o_vld && !i_rdy, o_data/o_eor/o_eof SHALL hold stable and o_vld stay high.
REQ-028 o_vld SHALL rise on the second rising edge after the edge sampling i_start.
REQ-029 With i_rdy held high, throughput SHALL be one pixel per cycle, no bubbles within a frame.
REQ-030 DRAIN SHALL go IDLE and pulse o_done in the cycle after the eof pixel transfers.
REQ-031 o_busy SHALL be high in RUN and DRAIN, low in IDLE.
REQ-032 Row/col counters SHALL wrap col to 0 and increment row at col=W-1; W=MAX_IMG_W and H=MAX_IMG_H SHALL not overflow ADDR_W.

Reset
REQ-033 i_rst_n=0 at a rising edge SHALL force IDLE, empty FIFO, clear counters and in-flight count.
REQ-034 Reset outputs SHALL be o_vld=0, o_eor=0, o_eof=0, o_rd_en=0, o_busy=0, o_done=0, o_data=0, o_rd_addr=0.
REQ-035 Reset mid-frame SHALL abandon the frame; data returning after reset SHALL be discarded; no o_done.

Structure
REQ-036 State encoding (IDLE/RUN/DRAIN) SHALL live in a shared stream package alongside stream tag widths.
REQ-037 The 2-entry output FIFO SHALL be one sub-module, stream_fifo2, carrying {eor, eof, data}.

Verification
REQ-038 4x3 frame, memory data=address, i_rdy=1 -> 12 pixels 0..11 back-to-back, o_eor at 3,7,11, o_eof at 11 only, o_done one cycle after pixel 11.
REQ-039 4x3 frame, i_rdy pattern 1,0,0,1 repeating -> same 12 pixels in order, outputs stable during every stall, reads never exceed 2 outstanding.
REQ-040 i_start with i_img_w=0, i_img_h=5 -> o_done next cycle, o_vld never high, o_rd_en never high.
REQ-041 i_rst_n low for one cycle after pixel 5 of a 4x3 frame -> o_vld low next cycle, no o_done; new 2x2 frame then streams 0..3 correctly.
REQ-042 i_start pulsed again during a 4x3 frame -> ignored, exactly 12 pixels and one o_done.
REQ-043 640x2 frame, i_rdy=1 -> o_eor at pixels 639 and 1279, o_eof at 1279, last address 1279.
